// File: rtl/reg_reduce_pipe.sv
// Registered N-input AND/OR/XOR reduction with optional inversion, optional output
// register stages, valid/ready flow control and a saturating count of delivered ones.
module reg_reduce_pipe #(
    parameter int WIDTH      = 2,
    parameter int OUT_STAGES = 0,
    parameter int COUNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_op,
    input  logic               in_inv,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_data,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               clr,
    output logic [COUNT_W-1:0] ones_cnt
);

    logic [WIDTH-1:0]    s0_data;
    logic [1:0]          s0_op;
    logic                s0_inv;
    logic                s0_valid;
    logic                red;
    logic                res;
    logic [OUT_STAGES+1:0] rdy;
    logic                deliver;

    always_comb begin
        red = &s0_data;
        case (s0_op)
            2'b01:   red = |s0_data;
            2'b10:   red = ^s0_data;
            default: red = &s0_data;
        endcase
        res = red ^ s0_inv;
    end

    // rdy[i] is the accept condition of stage i; rdy[OUT_STAGES+1] is the downstream
    assign rdy[OUT_STAGES+1] = out_ready;
    assign rdy[0]            = !s0_valid || rdy[1];
    assign in_ready          = rdy[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_data  <= '0;
            s0_op    <= 2'b00;
            s0_inv   <= 1'b0;
            s0_valid <= 1'b0;
        end else if (rdy[0]) begin
            s0_valid <= in_valid;
            if (in_valid) begin
                s0_data <= in_data;
                s0_op   <= in_op;
                s0_inv  <= in_inv;
            end
        end
    end

    generate
        if (OUT_STAGES == 0) begin : g_direct
            assign out_data  = res;
            assign out_valid = s0_valid;
        end else begin : g_stages
            logic [OUT_STAGES:1] stg_bit;
            logic [OUT_STAGES:1] stg_vld;

            for (genvar i = 1; i <= OUT_STAGES; i++) begin : g_rdy
                assign rdy[i] = !stg_vld[i] || rdy[i+1];
            end

            // Data bits only move when a valid token moves in, so emptied stages keep their last bit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stg_bit <= '0;
                    stg_vld <= '0;
                end else begin
                    if (rdy[1]) begin
                        stg_vld[1] <= s0_valid;
                        if (s0_valid) stg_bit[1] <= res;
                    end
                    for (int i = 2; i <= OUT_STAGES; i++) begin
                        if (rdy[i]) begin
                            stg_vld[i] <= stg_vld[i-1];
                            if (stg_vld[i-1]) stg_bit[i] <= stg_bit[i-1];
                        end
                    end
                end
            end

            assign out_data  = stg_bit[OUT_STAGES];
            assign out_valid = stg_vld[OUT_STAGES];
        end
    endgenerate

    assign deliver = out_valid && out_ready;

    // Clear wins over a simultaneous counted delivery
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_cnt <= '0;
        end else if (clr) begin
            ones_cnt <= '0;
        end else if (deliver && out_data && (ones_cnt != '1)) begin
            ones_cnt <= ones_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_reduce_pipe.sv
// Directed bench for reg_reduce_pipe: three instances cover the legacy NAND case,
// operator sweep and back-pressure, counter saturation, and reset mid-stream.
module tb_reg_reduce_pipe;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    // Instance A: WIDTH=2, OUT_STAGES=0, COUNT_W=2
    logic [1:0] a_data;
    logic [1:0] a_op;
    logic       a_inv, a_valid, a_in_ready, a_out_data, a_out_valid, a_out_ready, a_clr;
    logic [1:0] a_cnt;

    // Instance B: WIDTH=8, OUT_STAGES=2, COUNT_W=8
    logic [7:0] b_data;
    logic [1:0] b_op;
    logic       b_inv, b_valid, b_in_ready, b_out_data, b_out_valid, b_out_ready, b_clr;
    logic [7:0] b_cnt;

    // Instance C: WIDTH=8, OUT_STAGES=3, COUNT_W=8
    logic [7:0] c_data;
    logic [1:0] c_op;
    logic       c_inv, c_valid, c_in_ready, c_out_data, c_out_valid, c_out_ready, c_clr;
    logic [7:0] c_cnt;

    reg_reduce_pipe #(.WIDTH(2), .OUT_STAGES(0), .COUNT_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_op(a_op), .in_inv(a_inv),
        .in_valid(a_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .clr(a_clr), .ones_cnt(a_cnt)
    );

    reg_reduce_pipe #(.WIDTH(8), .OUT_STAGES(2), .COUNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_op(b_op), .in_inv(b_inv),
        .in_valid(b_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .clr(b_clr), .ones_cnt(b_cnt)
    );

    reg_reduce_pipe #(.WIDTH(8), .OUT_STAGES(3), .COUNT_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_op(c_op), .in_inv(c_inv),
        .in_valid(c_valid), .in_ready(c_in_ready), .out_data(c_out_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .clr(c_clr), .ones_cnt(c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_in_ready, b_in_ready, c_in_ready} !== 3'b111)
            $display("[TB] FAIL reset_in_ready: got %b want 111", {a_in_ready, b_in_ready, c_in_ready});
        else n_pass++;
        n_checks++;
        if ({a_out_valid, b_out_valid, c_out_valid} !== 3'b000)
            $display("[TB] FAIL reset_out_valid: got %b want 000", {a_out_valid, b_out_valid, c_out_valid});
        else n_pass++;
        n_checks++;
        if ({a_out_data, b_out_data, c_out_data} !== 3'b000)
            $display("[TB] FAIL reset_out_data: got %b want 000", {a_out_data, b_out_data, c_out_data});
        else n_pass++;
        n_checks++;
        if (a_cnt !== 2'd0 || b_cnt !== 8'd0 || c_cnt !== 8'd0)
            $display("[TB] FAIL reset_ones_cnt: got %0d/%0d/%0d want 0/0/0", a_cnt, b_cnt, c_cnt);
        else n_pass++;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({a_in_ready, b_in_ready, c_in_ready, a_out_valid, b_out_valid, c_out_valid} !== 6'b111000)
            $display("[TB] FAIL post_reset_idle: got %b want 111000",
                     {a_in_ready, b_in_ready, c_in_ready, a_out_valid, b_out_valid, c_out_valid});
        else n_pass++;
    endtask

    task automatic test_legacy();
        logic [1:0] vec [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
        logic       exp [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        a_op = 2'b00; a_inv = 1'b1; a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_data  = vec[i];
            a_valid = 1'b1;
            tick();
            n_checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== exp[i])
                $display("[TB] FAIL legacy_nand[%0d]: got v=%b d=%b want v=1 d=%b", i, a_out_valid, a_out_data, exp[i]);
            else n_pass++;
        end
        a_valid = 1'b0;
        tick();
        n_checks++;
        if (a_cnt !== 2'd3)
            $display("[TB] FAIL legacy_ones_cnt: got %0d want 3", a_cnt);
        else n_pass++;
        n_checks++;
        if (a_out_valid !== 1'b0)
            $display("[TB] FAIL legacy_drain: got out_valid=%b want 0", a_out_valid);
        else n_pass++;
    endtask

    task automatic test_saturation();
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        n_checks++;
        if (a_cnt !== 2'd0)
            $display("[TB] FAIL sat_clear: got %0d want 0", a_cnt);
        else n_pass++;
        a_op = 2'b00; a_inv = 1'b1; a_data = 2'b00; a_out_ready = 1'b1;
        a_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        a_valid = 1'b0;
        tick();
        n_checks++;
        if (a_cnt !== 2'd3)
            $display("[TB] FAIL sat_five_ones: got %0d want 3", a_cnt);
        else n_pass++;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        a_clr   = 1'b1;
        n_checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 1'b1)
            $display("[TB] FAIL sat_pending_one: got v=%b d=%b want v=1 d=1", a_out_valid, a_out_data);
        else n_pass++;
        tick();
        a_clr = 1'b0;
        n_checks++;
        if (a_cnt !== 2'd0)
            $display("[TB] FAIL sat_clr_priority: got %0d want 0", a_cnt);
        else n_pass++;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tick();
        n_checks++;
        if (a_cnt !== 2'd1)
            $display("[TB] FAIL sat_after_clr: got %0d want 1", a_cnt);
        else n_pass++;
    endtask

    task automatic test_op_sweep();
        logic [7:0] vec [4] = '{8'hFF, 8'h00, 8'h07, 8'hFE};
        logic [1:0] ops [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic       exp [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        b_out_ready = 1'b1;
        for (int inv = 0; inv < 2; inv++) begin
            for (int j = 0; j < 4; j++) begin
                b_data  = vec[j];
                b_op    = ops[j];
                b_inv   = (inv == 1);
                b_valid = 1'b1;
                tick();
                b_valid = 1'b0;
                n_checks++;
                if (b_out_valid !== 1'b0)
                    $display("[TB] FAIL sweep_early1[op%0d inv%0d]: got out_valid=%b want 0", j, inv, b_out_valid);
                else n_pass++;
                tick();
                n_checks++;
                if (b_out_valid !== 1'b0)
                    $display("[TB] FAIL sweep_early2[op%0d inv%0d]: got out_valid=%b want 0", j, inv, b_out_valid);
                else n_pass++;
                tick();
                n_checks++;
                if (b_out_valid !== 1'b1 || b_out_data !== (exp[j] ^ (inv == 1)))
                    $display("[TB] FAIL sweep_result[op%0d inv%0d]: got v=%b d=%b want v=1 d=%b",
                             j, inv, b_out_valid, b_out_data, exp[j] ^ (inv == 1));
                else n_pass++;
                tick();
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vec [6] = '{8'h01, 8'h03, 8'h07, 8'h00, 8'h0F, 8'h1F};
        logic       exp [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int   sent = 0;
        int   rcv = 0;
        int   held = 0;
        logic stalled = 1'b0;
        logic held_bit = 1'b0;
        logic acc, del, exp_ready;
        b_op = 2'b10; b_inv = 1'b0;
        for (int c = 0; c < 40; c++) begin
            b_out_ready = !(c >= 2 && c <= 7);
            if (sent < 6) begin
                b_valid = 1'b1;
                b_data  = vec[sent];
            end else begin
                b_valid = 1'b0;
            end
            #1;
            exp_ready = !(held == 3 && !b_out_ready);
            n_checks++;
            if (b_in_ready !== exp_ready)
                $display("[TB] FAIL bp_in_ready[c%0d]: got %b want %b (held %0d)", c, b_in_ready, exp_ready, held);
            else n_pass++;
            if (stalled) begin
                n_checks++;
                if (b_out_valid !== 1'b1 || b_out_data !== held_bit)
                    $display("[TB] FAIL bp_hold[c%0d]: got v=%b d=%b want v=1 d=%b", c, b_out_valid, b_out_data, held_bit);
                else n_pass++;
            end
            acc = b_valid && b_in_ready;
            del = b_out_valid && b_out_ready;
            if (del) begin
                n_checks++;
                if (rcv >= 6)
                    $display("[TB] FAIL bp_extra[c%0d]: got delivery %0d want none", c, rcv);
                else if (b_out_data !== exp[rcv])
                    $display("[TB] FAIL bp_order[%0d]: got %b want %b", rcv, b_out_data, exp[rcv]);
                else n_pass++;
                rcv++;
            end
            stalled  = b_out_valid && !b_out_ready;
            held_bit = b_out_data;
            tick();
            if (acc) begin sent++; held++; end
            if (del) held--;
        end
        n_checks++;
        if (rcv !== 6 || sent !== 6)
            $display("[TB] FAIL bp_count: got sent=%0d rcv=%0d want 6/6", sent, rcv);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        c_op = 2'b00; c_inv = 1'b0; c_data = 8'hFF; c_out_ready = 1'b1; c_clr = 1'b0;
        c_valid = 1'b1;
        tick();
        c_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (c_cnt !== 8'd1)
            $display("[TB] FAIL mid_pre_cnt: got %0d want 1", c_cnt);
        else n_pass++;
        c_out_ready = 1'b0;
        c_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        c_valid = 1'b0;
        n_checks++;
        if (c_in_ready !== 1'b0 || c_out_valid !== 1'b1)
            $display("[TB] FAIL mid_full: got in_ready=%b out_valid=%b want 0/1", c_in_ready, c_out_valid);
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (c_out_valid !== 1'b0 || c_cnt !== 8'd0 || c_in_ready !== 1'b1)
            $display("[TB] FAIL mid_async_reset: got v=%b cnt=%0d rdy=%b want 0/0/1", c_out_valid, c_cnt, c_in_ready);
        else n_pass++;
        #1 rst_n = 1'b1;
        c_out_ready = 1'b1;
        c_valid = 1'b1;
        tick();
        c_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (c_out_valid !== 1'b0)
                $display("[TB] FAIL mid_latency_early[%0d]: got out_valid=%b want 0", i, c_out_valid);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (c_out_valid !== 1'b1 || c_out_data !== 1'b1)
            $display("[TB] FAIL mid_latency: got v=%b d=%b want v=1 d=1", c_out_valid, c_out_data);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        a_data = '0; a_op = '0; a_inv = 0; a_valid = 0; a_out_ready = 1; a_clr = 0;
        b_data = '0; b_op = '0; b_inv = 0; b_valid = 0; b_out_ready = 1; b_clr = 0;
        c_data = '0; c_op = '0; c_inv = 0; c_valid = 0; c_out_ready = 1; c_clr = 0;
        test_reset();
        test_legacy();
        test_saturation();
        test_op_sweep();
        test_back_to_back();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/reg_reduce_pipe.md
# reg_reduce_pipe

Parametrised, registered N-input reduction unit with a per-token selectable operator (AND/OR/XOR, optional inversion) and valid/ready flow control. It is the generalised successor of the two-input registered-NAND test circuit. Input bits and the operator are captured in one register stage, reduced to a single bit, and then optionally delayed through extra output stages. A saturating counter tallies delivered results equal to 1. It is a sequential SAT/equivalence benchmark generator target and a reusable datapath leaf.

## Interface
Parameters:
- WIDTH, 2: number of input bits reduced; ≥2.
- OUT_STAGES, 0: registered stages after the reduction; 0..4.
- COUNT_W, 8: width of the ones counter; ≥1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset; deassertion is synchronous to clk.
- in_data  in  WIDTH  operand bits.
- in_op  in  2  00 AND, 01 OR, 10 XOR, 11 AND (reserved alias).
- in_inv  in  1  invert the reduction result.
- in_valid  in  1  token offered.
- in_ready  out  1  unit accepts the token this cycle.
- out_data  out  1  result bit.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- clr  in  1  synchronous clear of ones_cnt.
- ones_cnt  out  COUNT_W  number of delivered tokens with out_data=1, saturating.

## Operation
- Stage S0 is the capture register. It holds data, op, inv and a valid bit.
- S0 loads when in_valid && in_ready.
- The reduction is computed from S0 contents: r = op(S0.data) ^ S0.inv.
- With OUT_STAGES=0, out_data = r combinationally from S0 and out_valid = S0.valid.
- With OUT_STAGES=k>0, stages S1..Sk each register {bit, valid}. S1 takes r. out_data and out_valid come from Sk.
- Per-stage advance rule: stage i accepts when it is empty or stage i+1 (or downstream, for the last stage) accepts this cycle.
  - in_ready = S0 accept condition.
  - The ready chain is combinational from out_ready back to in_ready.
  - There are no bubbles: a full pipeline with out_ready=1 sustains 1 token/cycle.
- A stalled stage holds its contents unchanged. Data must not change while out_valid && !out_ready.
- When a stage is not loaded and its contents advance, its valid bit clears. Its data bits hold their last value.
- Counter behaviour:
  - Delivery is defined as out_valid && out_ready.
  - ones_cnt increments by 1 on a delivery with out_data=1.
  - It saturates at 2^COUNT_W−1 and does not wrap.
- clr has priority: if clr=1, ones_cnt becomes 0 next cycle even when a 1-result is delivered in the same cycle. That token is not counted.
- Reset state:
  - All valid bits 0.
  - S0 data 0, op 00, inv 0; all stage bits 0.
  - out_valid 0 and out_data 0 (for OUT_STAGES=0 this follows from the AND of zeros).
  - ones_cnt 0.
  - in_ready 1 during and after reset.
- Reset asserted mid-operation discards every in-flight token immediately (asynchronous). No partial delivery is counted.

## Timing
- Latency from the accept edge to out_valid, with no stall: 1 + OUT_STAGES cycles. The result becomes visible after the edge that captures S0 (k=0), or k edges later.
- Throughput is 1 token/cycle. Capacity is 1 + OUT_STAGES tokens.
- in_ready may drop in the same cycle out_ready drops, but only when all stages are valid.
- When the pipeline is full and out_ready=0, in_ready=0. A token offered then is not captured, and in_valid/in_data must be held by the source.
- Simultaneous accept at S0 and delivery at the output in one cycle is legal and keeps occupancy constant.
- ones_cnt updates on the edge at which delivery occurs and is visible the following cycle.

## Test plan
- Legacy equivalence (WIDTH=2, OUT_STAGES=0, op=00, inv=1, out_ready=1):
  - in_data=11 accepted → out_data=0 next cycle.
  - in_data=01, 10, 00 → out_data=1.
  - ones_cnt=3 after the four tokens.
- Operator sweep (WIDTH=8, OUT_STAGES=2):
  - AND(FF)=1, OR(00)=0, XOR(0x07)=1, op=11 on 0xFE gives 0; inv=1 flips each.
  - Each result appears exactly 3 cycles after its accept.
- Back-pressure (OUT_STAGES=2, stream of 6 tokens, out_ready=0 for cycles 2–7):
  - in_ready falls once 3 tokens are held.
  - out_data is held stable.
  - All 6 results are delivered in order, with none lost or duplicated, after out_ready=1.
- Counter saturation and clear (COUNT_W=2):
  - Deliver 5 ones → ones_cnt=3.
  - clr together with a 1-delivery → ones_cnt=0.
  - Next 1-delivery → 1.
- Reset mid-stream (OUT_STAGES=3, 4 tokens in flight):
  - Assert rst_n=0 for a partial cycle → out_valid=0 immediately, ones_cnt=0, in_ready=1.
  - After release, a fresh token emerges after exactly 4 cycles.
